dma_read_engine: RTL and testbench

DMA_READ_ENGINE -- requirements
Module: dma_read_engine

---
 rtl/dma_read_engine.sv | 211 +++++++++++++++++++++
 tb/tb_dma_read_engine.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_engine.sv
// dma_read_engine: copies a descriptor's worth of 32-byte beats from an AXI read port into SRAM.
// One AR burst is outstanding at a time. Bursts are capped by MAX_BURST and never cross a 4 KB
// boundary. The SRAM pointer advances by one word per beat.
// Optional feature: define DMA_RRESP_CHECK_EN to flag non-OKAY rresp or misplaced rlast on `error`.
// When the macro is undefined, rresp and rlast are ignored and `error` is tied low.
module dma_read_engine #(
  parameter int unsigned EXT_ADDR_W  = 40,
  parameter int unsigned EXT_DATA_W  = 256,
  parameter int unsigned SRAM_ADDR_W = 20,
  parameter int unsigned MAX_BURST   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,

  // Descriptor handshake
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [EXT_ADDR_W-1:0]  cmd_ext_addr,
  input  logic [SRAM_ADDR_W-1:0] cmd_sram_addr,
  input  logic [15:0]            cmd_len,

  // Status
  output logic                   busy,
  output logic                   done,
  output logic                   error,

  // AXI read address channel
  output logic [EXT_ADDR_W-1:0]  axi_araddr,
  output logic [7:0]             axi_arlen,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,

  // AXI read data channel
  input  logic [EXT_DATA_W-1:0]  axi_rdata,
  input  logic [1:0]             axi_rresp,
  input  logic                   axi_rlast,
  input  logic                   axi_rvalid,
  output logic                   axi_rready,

  // SRAM write port
  output logic                   sram_wr_en,
  output logic [SRAM_ADDR_W-1:0] sram_wr_addr,
  output logic [EXT_DATA_W-1:0]  sram_wr_data,
  input  logic                   sram_wr_ready
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  state_e                 state_q, state_d;
  logic [EXT_ADDR_W-1:0]  ext_addr_q, ext_addr_d;
  logic [SRAM_ADDR_W-1:0] sram_ptr_q, sram_ptr_d;
  logic [15:0]            remaining_q, remaining_d;
  logic [7:0]             beats_q, beats_d;
  logic [7:0]             beat_cnt_q, beat_cnt_d;
  logic                   arvalid_q, arvalid_d;

  logic [16:0]            rem_w, max_w, bnd_w, beats_w;
  logic [7:0]             burst_beats;
  logic                   r_hs;
  logic                   last_beat;
  logic [15:0]            rem_after;

  // Low 5 address bits are dropped on latch; they never reach any register.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_ext_addr[4:0];

  // Burst size: min(remaining, MAX_BURST, beats left before the next 4 KB boundary).
  assign rem_w = {1'b0, remaining_q};
  assign max_w = 17'(MAX_BURST);
  assign bnd_w = 17'd128 - {10'd0, ext_addr_q[11:5]};

  // Select the smallest of the three burst limits
  always_comb begin
    beats_w = rem_w;
    if (max_w < beats_w) beats_w = max_w;
    if (bnd_w < beats_w) beats_w = bnd_w;
  end

  assign burst_beats = beats_w[7:0];

  assign r_hs      = axi_rvalid & axi_rready;
  assign last_beat = (beat_cnt_q == beats_q - 8'd1);
  assign rem_after = remaining_q - {8'd0, beats_q};

  // Combinational outputs decoded from the registered state
  always_comb begin
    cmd_ready    = (state_q == StIdle);
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    axi_araddr   = ext_addr_q;
    axi_arlen    = (state_q == StAddr) ? (burst_beats - 8'd1) : 8'd0;
    axi_arvalid  = arvalid_q;
    axi_rready   = (state_q == StData) & sram_wr_ready;
    sram_wr_en   = r_hs;
    sram_wr_addr = sram_ptr_q;
    sram_wr_data = axi_rdata;
  end

`ifdef DMA_RRESP_CHECK_EN
  logic error_q, error_d;
  assign error = error_q;
`else
  logic unused_resp;
  assign unused_resp = ^{axi_rresp, axi_rlast};
  assign error       = 1'b0;
`endif

  // Next-state logic for the transfer FSM and its datapath registers
  always_comb begin
    state_d     = state_q;
    ext_addr_d  = ext_addr_q;
    sram_ptr_d  = sram_ptr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    beat_cnt_d  = beat_cnt_q;
    arvalid_d   = arvalid_q;
`ifdef DMA_RRESP_CHECK_EN
    error_d     = error_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          ext_addr_d  = {cmd_ext_addr[EXT_ADDR_W-1:5], 5'd0};
          sram_ptr_d  = cmd_sram_addr;
          remaining_d = cmd_len;
`ifdef DMA_RRESP_CHECK_EN
          error_d     = 1'b0;
`endif
          if (cmd_len == 16'd0) begin
            state_d = StDone;
          end else begin
            state_d   = StAddr;
            arvalid_d = 1'b1;
          end
        end
      end

      StAddr: begin
        // araddr/arlen derive from registers that only change on a final beat, so they hold
        if (axi_arready) begin
          arvalid_d  = 1'b0;
          beats_d    = burst_beats;
          beat_cnt_d = 8'd0;
          state_d    = StData;
        end
      end

      StData: begin
        if (r_hs) begin
          sram_ptr_d = sram_ptr_q + 1'b1;
          beat_cnt_d = beat_cnt_q + 8'd1;
`ifdef DMA_RRESP_CHECK_EN
          if ((axi_rresp != 2'b00) || (axi_rlast != last_beat)) error_d = 1'b1;
`endif
          if (last_beat) begin
            ext_addr_d  = ext_addr_q + EXT_ADDR_W'({beats_q, 5'd0});
            remaining_d = rem_after;
            if (rem_after == 16'd0) begin
              state_d = StDone;
            end else begin
              state_d   = StAddr;
              arvalid_d = 1'b1;
            end
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset abandons any descriptor in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ext_addr_q  <= '0;
      sram_ptr_q  <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      arvalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_addr_q  <= ext_addr_d;
      sram_ptr_q  <= sram_ptr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      beat_cnt_q  <= beat_cnt_d;
      arvalid_q   <= arvalid_d;
    end
  end

`ifdef DMA_RRESP_CHECK_EN
  // Sticky error flag, cleared when the next descriptor is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end
`endif

endmodule

// File: tb/tb_dma_read_engine.sv
// Directed bench for dma_read_engine: plays an AXI read slave and an SRAM sink cycle by cycle,
// logs AR requests and SRAM writes, and compares them against hand-computed expectations.
module tb_dma_read_engine;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [39:0]  cmd_ext_addr;
  logic [19:0]  cmd_sram_addr;
  logic [15:0]  cmd_len;
  logic         busy;
  logic         done;
  logic         error;
  logic [39:0]  axi_araddr;
  logic [7:0]   axi_arlen;
  logic         axi_arvalid;
  logic         axi_arready;
  logic [255:0] axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rlast;
  logic         axi_rvalid;
  logic         axi_rready;
  logic         sram_wr_en;
  logic [19:0]  sram_wr_addr;
  logic [255:0] sram_wr_data;
  logic         sram_wr_ready;

  dma_read_engine #(
    .EXT_ADDR_W (40),
    .EXT_DATA_W (256),
    .SRAM_ADDR_W(20),
    .MAX_BURST  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_ext_addr (cmd_ext_addr),
    .cmd_sram_addr(cmd_sram_addr),
    .cmd_len      (cmd_len),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .axi_araddr   (axi_araddr),
    .axi_arlen    (axi_arlen),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_rdata    (axi_rdata),
    .axi_rresp    (axi_rresp),
    .axi_rlast    (axi_rlast),
    .axi_rvalid   (axi_rvalid),
    .axi_rready   (axi_rready),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .sram_wr_ready(sram_wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [39:0]  ar_addr_log [16];
  logic [7:0]   ar_len_log  [16];
  logic [19:0]  wr_addr_log [64];
  logic [255:0] wr_data_log [64];
  int ar_n, wr_n, done_n, done_cyc, desc_id;
  logic exp_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int d, input int i);
    logic [31:0] w;
    w = 32'(d) * 32'h0001_0000 + 32'(i);
    return {8{w}};
  endfunction

  task automatic check_writes(input logic [19:0] s, input int len);
    logic [19:0] ea;
    chk("wr_count", 64'(wr_n), 64'(len));
    for (int i = 0; i < len && i < 64; i++) begin
      ea = s + 20'(i);
      chk("wr_addr", 64'(wr_addr_log[i]), 64'(ea));
      n_cmp++;
      assert (wr_data_log[i] === pat(desc_id, i)) else begin
        n_bad++;
        $error("FAIL wr_data[%0d] got=%0h exp=%0h", i, wr_data_log[i], pat(desc_id, i));
      end
    end
  endtask

  task automatic check_ar(input int idx, input logic [39:0] a, input logic [7:0] l);
    if (idx < 16) begin
      chk("ar_addr", 64'(ar_addr_log[idx]), 64'(a));
      chk("ar_len", 64'(ar_len_log[idx]), 64'(l));
    end
  endtask

  // Issue one descriptor and act as AXI slave + SRAM sink until done (or abort by reset).
  task automatic run_desc(input logic [39:0] a, input logic [19:0] s, input logic [15:0] len,
                          input bit toggle, input int bad_beat, input int abort_after);
    int r_left, new_left, rd_idx, cyc;
    bit fin, abort;
    ar_n = 0; wr_n = 0; done_n = 0; done_cyc = -1; desc_id++;
    r_left = 0; rd_idx = 0; cyc = 0; fin = 1'b0; abort = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ext_addr = a; cmd_sram_addr = s; cmd_len = len;
    #1 chk("cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    while (!fin) begin
      @(negedge clk);
      cmd_valid     = 1'b0;
      axi_arready   = 1'b1;
      axi_rvalid    = (r_left > 0);
      axi_rlast     = (r_left == 1);
      axi_rdata     = pat(desc_id, rd_idx);
      axi_rresp     = (r_left > 0 && rd_idx == bad_beat) ? 2'd2 : 2'd0;
      sram_wr_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      #1;
      new_left = r_left;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (r_left > 0) chk("rready_track", 64'(axi_rready), 64'(sram_wr_ready));
      if (axi_arvalid) begin
        if (ar_n < 16) begin
          ar_addr_log[ar_n] = axi_araddr;
          ar_len_log[ar_n]  = axi_arlen;
        end
        ar_n++;
        chk("one_outstanding", 64'(r_left), 64'd0);
        new_left = int'(axi_arlen) + 1;
      end
      if (axi_rvalid && axi_rready) begin
        chk("wr_en", 64'(sram_wr_en), 64'd1);
        if (wr_n < 64) begin
          wr_addr_log[wr_n] = sram_wr_addr;
          wr_data_log[wr_n] = sram_wr_data;
        end
        wr_n++; rd_idx++;
        new_left = r_left - 1;
        if (abort_after >= 0 && wr_n >= abort_after) abort = 1'b1;
      end
      if (abort) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_arvalid", 64'(axi_arvalid), 64'd0);
        chk("rst_rready", 64'(axi_rready), 64'd0);
        chk("rst_wr_en", 64'(sram_wr_en), 64'd0);
        repeat (3) begin
          @(negedge clk);
          if (done) done_n++;
        end
        axi_rvalid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        fin = 1'b1;
      end else begin
        if (done_cyc >= 0 && cyc >= done_cyc + 3) fin = 1'b1;
        if (cyc >= 400) begin
          chk("timeout", 64'd0, 64'd1);
          fin = 1'b1;
        end
        @(posedge clk);
        r_left = new_left;
        cyc++;
      end
    end
  endtask

  initial begin
    desc_id = 0;
`ifdef DMA_RRESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_ext_addr = '0; cmd_sram_addr = '0; cmd_len = '0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0; axi_rvalid = 1'b0;
    sram_wr_ready = 1'b0;
    #12;
    // Reset values
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_error", 64'(error), 64'd0);
    chk("reset_arvalid", 64'(axi_arvalid), 64'd0);
    chk("reset_rready", 64'(axi_rready), 64'd0);
    chk("reset_wr_en", 64'(sram_wr_en), 64'd0);
    chk("reset_araddr", 64'(axi_araddr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);

    // R beats presented while idle must be refused
    @(negedge clk);
    axi_rvalid = 1'b1; sram_wr_ready = 1'b1;
    #1;
    chk("idle_rready", 64'(axi_rready), 64'd0);
    chk("idle_wr_en", 64'(sram_wr_en), 64'd0);
    axi_rvalid = 1'b0;

    // Single short burst
    run_desc(40'h10_00, 20'h10, 16'd4, 1'b0, -1, -1);
    chk("t1_ar_n", 64'(ar_n), 64'd1);
    check_ar(0, 40'h1000, 8'd3);
    check_writes(20'h10, 4);
    chk("t1_done_n", 64'(done_n), 64'd1);
    chk("t1_done_cyc", 64'(done_cyc), 64'd5);

    // MAX_BURST splitting
    run_desc(40'h0, 20'h100, 16'd40, 1'b0, -1, -1);
    chk("t2_ar_n", 64'(ar_n), 64'd3);
    check_ar(0, 40'h000, 8'd15);
    check_ar(1, 40'h200, 8'd15);
    check_ar(2, 40'h400, 8'd7);
    check_writes(20'h100, 40);
    chk("t2_done_n", 64'(done_n), 64'd1);

    // 4 KB boundary split
    run_desc(40'hFC0, 20'h0, 16'd4, 1'b0, -1, -1);
    chk("t3_ar_n", 64'(ar_n), 64'd2);
    check_ar(0, 40'hFC0, 8'd1);
    check_ar(1, 40'h1000, 8'd1);
    check_writes(20'h0, 4);

    // Zero-length descriptor
    run_desc(40'h5000, 20'h20, 16'd0, 1'b0, -1, -1);
    chk("t4_ar_n", 64'(ar_n), 64'd0);
    chk("t4_wr_n", 64'(wr_n), 64'd0);
    chk("t4_done_cyc", 64'(done_cyc), 64'd0);
    chk("t4_done_n", 64'(done_n), 64'd1);
    chk("t4_error", 64'(error), 64'd0);

    // SRAM backpressure toggling, SRAM pointer wrap
    run_desc(40'h2000, 20'hFFFFE, 16'd8, 1'b1, -1, -1);
    chk("t5_ar_n", 64'(ar_n), 64'd1);
    check_ar(0, 40'h2000, 8'd7);
    check_writes(20'hFFFFE, 8);
    chk("t5_done_n", 64'(done_n), 64'd1);

    // Low address bits ignored
    run_desc(40'h301F, 20'h40, 16'd2, 1'b0, -1, -1);
    check_ar(0, 40'h3000, 8'd1);
    check_writes(20'h40, 2);

    // External address wrap at the top of the address space
    run_desc(40'hFF_FFFF_FFE0, 20'h80, 16'd2, 1'b0, -1, -1);
    chk("t9_ar_n", 64'(ar_n), 64'd2);
    check_ar(0, 40'hFF_FFFF_FFE0, 8'd0);
    check_ar(1, 40'h0, 8'd0);
    check_writes(20'h80, 2);

    // SLVERR on the second beat
    run_desc(40'h4000, 20'h200, 16'd4, 1'b0, 1, -1);
    check_writes(20'h200, 4);
    chk("t7_done_n", 64'(done_n), 64'd1);
    chk("t7_error", 64'(error), 64'(exp_err));

    // Error cleared by next descriptor
    run_desc(40'h1000, 20'h10, 16'd4, 1'b0, -1, -1);
    chk("t8_error_clr", 64'(error), 64'd0);
    check_writes(20'h10, 4);

    // Reset in the middle of DATA
    run_desc(40'h6000, 20'h300, 16'd8, 1'b0, -1, 3);
    chk("t10_no_done", 64'(done_n), 64'd0);

    // Engine still usable after the abort
    run_desc(40'h7000, 20'h400, 16'd3, 1'b0, -1, -1);
    check_ar(0, 40'h7000, 8'd2);
    check_writes(20'h400, 3);
    chk("t11_done_n", 64'(done_n), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
